// File: rtl/aes128_mode_ctrl.sv
// Block-cipher mode controller: sits between a streaming data port and a single-block AES-128 core,
// applying ECB/CBC/CFB/OFB/CTR chaining with one block in flight at a time.
module aes128_mode_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [127:0]     iv,
  input  logic             sess_start,
  input  logic             sess_end,
  output logic             sess_busy,
  output logic             mode_err,
  input  logic [127:0]     din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [127:0]     dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [127:0]     aes_plain_text,
  output logic             aes_cipher_en,
  input  logic [127:0]     aes_cipher_text,
  input  logic             aes_cipher_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_e;

  localparam logic [2:0] MODE_ECB = 3'd0;
  localparam logic [2:0] MODE_CBC = 3'd1;
  localparam logic [2:0] MODE_CFB = 3'd2;
  localparam logic [2:0] MODE_OFB = 3'd3;
  localparam logic [2:0] MODE_CTR = 3'd4;

  state_e             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [127:0]       chain_q, chain_d;
  logic [127:0]       pt_q, pt_d;
  logic [127:0]       dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic [127:0]       plain_q, plain_d;
  logic               cipher_en_q, cipher_en_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               end_q, end_d;
  logic               mode_err_q, mode_err_d;

  logic [127:0]       ct_xor_pt;

  assign ct_xor_pt = aes_cipher_text ^ pt_q;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    chain_d      = chain_q;
    pt_d         = pt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    plain_d      = plain_q;
    cipher_en_d  = 1'b0;
    blk_cnt_d    = blk_cnt_q;
    end_d        = end_q;
    mode_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sess_start) begin
          if (mode <= MODE_CTR) begin
            chain_d   = iv;
            mode_d    = mode;
            blk_cnt_d = '0;
            end_d     = 1'b0;
            state_d   = LOAD;
          end else begin
            mode_err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (sess_end) begin
          state_d = IDLE;
        end else if (din_valid) begin
          pt_d        = din;
          cipher_en_d = 1'b1;
          state_d     = RUN;
          case (mode_q)
            MODE_ECB: plain_d = din;
            MODE_CBC: plain_d = din ^ chain_q;
            default:  plain_d = chain_q;
          endcase
        end
      end

      RUN: begin
        if (sess_end) end_d = 1'b1;
        if (aes_cipher_ready) begin
          dout_valid_d = 1'b1;
          state_d      = OUT;
          case (mode_q)
            MODE_ECB: dout_d = aes_cipher_text;
            MODE_CBC: begin
              dout_d  = aes_cipher_text;
              chain_d = aes_cipher_text;
            end
            MODE_CFB: begin
              dout_d  = ct_xor_pt;
              chain_d = ct_xor_pt;
            end
            MODE_OFB: begin
              dout_d  = ct_xor_pt;
              chain_d = aes_cipher_text;
            end
            MODE_CTR: begin
              dout_d  = ct_xor_pt;
              chain_d = chain_q + 128'd1;
            end
            default: dout_d = aes_cipher_text;
          endcase
        end
      end

      OUT: begin
        if (sess_end) end_d = 1'b1;
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          end_d        = 1'b0;
          if (blk_cnt_q != '1) blk_cnt_d = blk_cnt_q + CNT_W'(1);
          // A session end seen during this block defers the return to IDLE until the result is taken
          state_d = (end_q || sess_end) ? IDLE : LOAD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      chain_q      <= '0;
      pt_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      plain_q      <= '0;
      cipher_en_q  <= 1'b0;
      blk_cnt_q    <= '0;
      end_q        <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      chain_q      <= chain_d;
      pt_q         <= pt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      plain_q      <= plain_d;
      cipher_en_q  <= cipher_en_d;
      blk_cnt_q    <= blk_cnt_d;
      end_q        <= end_d;
      mode_err_q   <= mode_err_d;
    end
  end

  assign sess_busy      = (state_q != IDLE);
  assign mode_err       = mode_err_q;
  assign din_ready      = (state_q == LOAD) && !sess_end;
  assign dout           = dout_q;
  assign dout_valid     = dout_valid_q;
  assign blk_cnt        = blk_cnt_q;
  assign aes_plain_text = plain_q;
  assign aes_cipher_en  = cipher_en_q;

endmodule

// File: tb/tb_aes128_mode_ctrl.sv
// Directed testbench for aes128_mode_ctrl; the bench stands in for the AES core and
// supplies hand-computed cipher outputs.
module tb_aes128_mode_ctrl;
  localparam int CNT_W = 16;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk_sys = 1'b0;
  logic             rst;
  logic [2:0]       mode;
  logic [127:0]     iv;
  logic             sess_start;
  logic             sess_end;
  logic             sess_busy;
  logic             mode_err;
  logic [127:0]     din;
  logic             din_valid;
  logic             din_ready;
  logic [127:0]     dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CNT_W-1:0] blk_cnt;
  logic [127:0]     aes_plain_text;
  logic             aes_cipher_en;
  logic [127:0]     aes_cipher_text;
  logic             aes_cipher_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_sys = ~clk_sys;

  aes128_mode_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .mode             (mode),
    .iv               (iv),
    .sess_start       (sess_start),
    .sess_end         (sess_end),
    .sess_busy        (sess_busy),
    .mode_err         (mode_err),
    .din              (din),
    .din_valid        (din_valid),
    .din_ready        (din_ready),
    .dout             (dout),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .blk_cnt          (blk_cnt),
    .aes_plain_text   (aes_plain_text),
    .aes_cipher_en    (aes_cipher_en),
    .aes_cipher_text  (aes_cipher_text),
    .aes_cipher_ready (aes_cipher_ready)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic startSession(input logic [2:0] m, input logic [127:0] iv_v);
    mode       = m;
    iv         = iv_v;
    sess_start = 1'b1;
    tick();
    sess_start = 1'b0;
  endtask

  // One block from LOAD through the output handshake, cipher answering in the first RUN cycle
  task automatic applyStimulus(input string tag, input logic [127:0] d, input logic [127:0] ct,
                               input logic [127:0] exp_plain, input logic [127:0] exp_dout,
                               input logic end_in_out);
    checkOutput({tag, " din_ready"}, 128'(din_ready), 128'd1);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checkOutput({tag, " cipher_en"}, 128'(aes_cipher_en), 128'd1);
    checkOutput({tag, " plain"}, aes_plain_text, exp_plain);
    aes_cipher_text  = ct;
    aes_cipher_ready = 1'b1;
    tick();
    aes_cipher_ready = 1'b0;
    checkOutput({tag, " dout_valid"}, 128'(dout_valid), 128'd1);
    checkOutput({tag, " dout"}, dout, exp_dout);
    if (end_in_out) begin
      sess_end = 1'b1;
      tick();
      sess_end = 1'b0;
      checkOutput({tag, " held after end"}, 128'(dout_valid), 128'd1);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = '0; iv = '0; sess_start = 1'b0; sess_end = 1'b0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    aes_cipher_text = '0; aes_cipher_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst sess_busy", 128'(sess_busy), 128'd0);
    checkOutput("rst din_ready", 128'(din_ready), 128'd0);
    checkOutput("rst dout_valid", 128'(dout_valid), 128'd0);
    checkOutput("rst blk_cnt", 128'(blk_cnt), 128'd0);
    checkOutput("rst cipher_en", 128'(aes_cipher_en), 128'd0);
    checkOutput("rst plain", aes_plain_text, 128'd0);
    checkOutput("rst dout", dout, 128'd0);

    // Reserved mode is rejected
    startSession(3'd5, 128'd0);
    checkOutput("err pulse", 128'(mode_err), 128'd1);
    checkOutput("err busy", 128'(sess_busy), 128'd0);
    checkOutput("err din_ready", 128'(din_ready), 128'd0);
    tick();
    checkOutput("err one cycle", 128'(mode_err), 128'd0);

    // ECB with FIPS-197 vector, cipher latency L=2, output back-pressure
    startSession(3'd0, 128'd0);
    checkOutput("ecb busy", 128'(sess_busy), 128'd1);
    checkOutput("ecb din_ready", 128'(din_ready), 128'd1);
    din = PT_FIPS;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checkOutput("ecb cipher_en", 128'(aes_cipher_en), 128'd1);
    checkOutput("ecb plain", aes_plain_text, PT_FIPS);
    checkOutput("ecb run din_ready", 128'(din_ready), 128'd0);
    tick();
    checkOutput("ecb cipher_en drop", 128'(aes_cipher_en), 128'd0);
    tick();
    checkOutput("ecb no early dout", 128'(dout_valid), 128'd0);
    aes_cipher_text  = CT_FIPS;
    aes_cipher_ready = 1'b1;
    tick();
    aes_cipher_ready = 1'b0;
    aes_cipher_text  = '0;
    checkOutput("ecb dout_valid", 128'(dout_valid), 128'd1);
    checkOutput("ecb dout", dout, CT_FIPS);
    sess_start = 1'b1;
    mode       = 3'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold dout", dout, CT_FIPS);
      checkOutput("hold dout_valid", 128'(dout_valid), 128'd1);
      checkOutput("hold din_ready", 128'(din_ready), 128'd0);
      checkOutput("hold cipher_en", 128'(aes_cipher_en), 128'd0);
      checkOutput("hold start ignored", 128'(mode_err), 128'd0);
    end
    sess_start = 1'b0;
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    checkOutput("ecb blk_cnt", 128'(blk_cnt), 128'd1);
    checkOutput("ecb back to LOAD", 128'(din_ready), 128'd1);
    checkOutput("ecb dout_valid low", 128'(dout_valid), 128'd0);
    sess_end  = 1'b1;
    din_valid = 1'b1;
    #1;
    checkOutput("load end din_ready", 128'(din_ready), 128'd0);
    tick();
    sess_end  = 1'b0;
    din_valid = 1'b0;
    checkOutput("load end idle", 128'(sess_busy), 128'd0);
    checkOutput("load end no cipher", 128'(aes_cipher_en), 128'd0);
    checkOutput("ecb blk_cnt kept", 128'(blk_cnt), 128'd1);

    // CBC, iv=0: second block's cipher input is the first ciphertext
    startSession(3'd1, 128'd0);
    checkOutput("cbc blk_cnt cleared", 128'(blk_cnt), 128'd0);
    applyStimulus("cbc1", PT_FIPS, CT_FIPS, PT_FIPS, CT_FIPS, 1'b0);
    applyStimulus("cbc2", 128'd0, 128'h0123456789abcdef0123456789abcdef, CT_FIPS,
                  128'h0123456789abcdef0123456789abcdef, 1'b1);
    checkOutput("cbc end idle", 128'(sess_busy), 128'd0);
    checkOutput("cbc blk_cnt", 128'(blk_cnt), 128'd2);

    // CTR from all-ones: counter wraps to zero for block 2
    startSession(3'd4, {128{1'b1}});
    applyStimulus("ctr1", PT_FIPS, 128'hffffffff00000000ffffffff00000000, {128{1'b1}},
                  128'hffeeddcc4455667777665544ccddeeff, 1'b0);
    aes_cipher_ready = 1'b1;
    tick();
    aes_cipher_ready = 1'b0;
    checkOutput("stray ready dout_valid", 128'(dout_valid), 128'd0);
    checkOutput("stray ready din_ready", 128'(din_ready), 128'd1);
    applyStimulus("ctr2", 128'h1, 128'h3, 128'h0, 128'h2, 1'b1);
    checkOutput("ctr end idle", 128'(sess_busy), 128'd0);
    checkOutput("ctr blk_cnt", 128'(blk_cnt), 128'd2);

    // CFB feeds back the output, OFB the raw cipher output
    startSession(3'd2, 128'ha5);
    applyStimulus("cfb1", 128'h0f, 128'hf0, 128'ha5, 128'hff, 1'b0);
    applyStimulus("cfb2", 128'h00, 128'h01, 128'hff, 128'h01, 1'b1);
    startSession(3'd3, 128'ha5);
    applyStimulus("ofb1", 128'h0f, 128'hf0, 128'ha5, 128'hff, 1'b0);
    applyStimulus("ofb2", 128'h00, 128'h01, 128'hf0, 128'h01, 1'b1);
    checkOutput("ofb end idle", 128'(sess_busy), 128'd0);

    // Reset while a block is at the cipher; the late ready must be ignored
    startSession(3'd0, 128'd0);
    din       = PT_FIPS;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst busy", 128'(sess_busy), 128'd0);
    checkOutput("midrst plain", aes_plain_text, 128'd0);
    aes_cipher_text  = CT_FIPS;
    aes_cipher_ready = 1'b1;
    tick();
    aes_cipher_ready = 1'b0;
    checkOutput("midrst dout_valid", 128'(dout_valid), 128'd0);
    checkOutput("midrst dout", dout, 128'd0);
    checkOutput("midrst blk_cnt", 128'(blk_cnt), 128'd0);
    checkOutput("midrst still idle", 128'(sess_busy), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aes128_mode_ctrl.md
AES128_MODE_CTRL -- requirements
Module: aes128_mode_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the block counter.
REQ-002 SHALL have port clk_sys  input  1  the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port mode  input  3  mode select: 0 ECB, 1 CBC, 2 CFB, 3 OFB, 4 CTR; 5-7 reserved.
REQ-005 SHALL have port iv  input  128  IV, or initial counter for CTR; sampled on session start.
REQ-006 SHALL have port sess_start  input  1  session start request.
REQ-007 SHALL have port sess_end  input  1  session end request.
REQ-008 SHALL have port sess_busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port mode_err  output  1  one-cycle pulse on a rejected start.
REQ-010 SHALL have ports din[127:0] input, din_valid input, din_ready output: plaintext block handshake.
REQ-011 SHALL have ports dout[127:0] output, dout_valid output, dout_ready input: result block handshake.
REQ-012 SHALL have port blk_cnt  output  CNT_W  number of blocks completed in the current session.
REQ-013 SHALL have ports aes_plain_text[127:0] output, aes_cipher_en output: to the cipher's plain_text and cipher_en.
REQ-014 SHALL have ports aes_cipher_text[127:0] input, aes_cipher_ready input: from the cipher's cipher_text and cipher_ready.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, OUT.
REQ-016 IDLE: when sess_start=1 and mode<=4, at the next edge SHALL set chain<=iv, mode_q<=mode, blk_cnt<=0, and enter LOAD.
REQ-017 IDLE: when sess_start=1 and mode>=5, SHALL pulse mode_err for one cycle and stay in IDLE.
REQ-018 sess_start SHALL be ignored in every state other than IDLE.
REQ-019 LOAD: din_ready SHALL equal NOT sess_end; on din_valid&din_ready the FSM SHALL capture pt<=din, load aes_plain_text, and enter RUN.
REQ-020 Cipher input by mode: ECB -> din; CBC -> din XOR chain; CFB, OFB and CTR -> chain.
REQ-021 aes_cipher_en SHALL be high for exactly the first cycle of RUN; aes_plain_text SHALL stay stable from RUN entry until the next accepted block.
REQ-022 RUN: on aes_cipher_ready=1 the FSM SHALL register dout, update chain, and enter OUT with dout_valid=1 on the next cycle.
REQ-023 Output by mode: ECB and CBC -> ct; CFB, OFB and CTR -> ct XOR pt (ct = aes_cipher_text).
REQ-024 Chain update by mode: CBC -> ct; CFB -> dout; OFB -> ct; CTR -> chain+1 modulo 2^128 (all-ones wraps to zero); ECB -> unchanged.
REQ-025 Latency: if a block is accepted at cycle T and aes_cipher_ready arrives at T+1+L, dout_valid SHALL rise at T+2+L.
REQ-026 OUT: dout and dout_valid SHALL hold while dout_ready=0; on dout_valid&dout_ready, blk_cnt SHALL increment (saturating at all-ones) and the FSM SHALL enter LOAD.
REQ-027 sess_end in LOAD SHALL send the FSM to IDLE at the next edge; a simultaneous din_valid is not accepted.
REQ-028 sess_end in RUN or OUT SHALL be latched; the FSM SHALL go to IDLE after the current block's dout handshake instead of entering LOAD.
REQ-029 aes_cipher_ready SHALL be ignored outside RUN.
REQ-030 din_ready SHALL be 0 in IDLE, RUN and OUT.
REQ-031 At most one block SHALL be outstanding at the cipher at any time.

Reset
REQ-032 When rst=1 at a clock edge: state SHALL be IDLE; chain, pt, dout, aes_plain_text, blk_cnt, mode_q and the latched end flag SHALL be 0; aes_cipher_en, dout_valid, din_ready, sess_busy and mode_err SHALL be 0.
REQ-033 Reset mid-operation SHALL abandon the in-flight block with no dout produced; a later aes_cipher_ready SHALL be ignored.

Verification
REQ-034 ECB: cipher key 000102030405060708090a0b0c0d0e0f, din 00112233445566778899aabbccddeeff -> dout 69c4e0d86a7b0430d8cdb78070b4c55a, blk_cnt=1.
REQ-035 CBC, iv=0, same key, blocks {00112233445566778899aabbccddeeff, 0} -> block 1 dout 69c4e0d86a7b0430d8cdb78070b4c55a; block 2 aes_plain_text = 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-036 CTR, iv=all-ones, two blocks -> aes_plain_text is ffff...ff for block 1 and 0 for block 2; dout = din XOR cipher output.
REQ-037 mode=5 with sess_start -> mode_err pulses once, sess_busy stays 0, din_ready stays 0.
REQ-038 dout_ready held low 5 cycles in OUT -> dout stable, din_ready=0, aes_cipher_en=0; the handshake then returns the FSM to LOAD.
REQ-039 rst pulsed in RUN, then aes_cipher_ready=1 -> FSM in IDLE, dout_valid=0, blk_cnt=0; sess_end in OUT -> IDLE after the handshake.
